// File: rtl/bitslice2_ctrl.sv
// bitslice2_ctrl: sequencing controller for one 16-word latch-based bitslice2.
// Arbitrates write/read requests and drives one-hot latch gates (DGWCLK) and
// read word-lines (RWL) straight from flops, so the latch gates are glitch-free.
// Read data is captured from the slice's DOUT after RD_LAT cycles of a stable RWL.
module bitslice2_ctrl #(
   parameter int WORDS  = 16,
   parameter int ADDR_W = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rsp_valid,
   output logic              rsp_data,
   input  logic              rsp_ready,
   output logic              DIN,
   output logic [WORDS-1:0]  DGWCLK,
   output logic [WORDS-1:0]  RWL,
   input  logic              DOUT
);

   typedef enum logic [2:0] {
      IDLE,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      RD_SEL,
      RD_RESP
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        lat_cnt;
   logic              prio_wr;

   function automatic logic [WORDS-1:0] onehot(input logic [ADDR_W-1:0] a);
      logic [WORDS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   // NOTE: the ready signals must be combinational because the handshake
   // completes on the same edge that valid is first seen. They are gated with
   // rst_n so that no request is acknowledged while reset is held.
   assign wr_ready = rst_n && (state == IDLE) && wr_valid && (!rd_valid || prio_wr);
   assign rd_ready = rst_n && (state == IDLE) && rd_valid && (!wr_valid || !prio_wr);

   // Sequencer: state, arbitration priority, and every slice-facing output register.
   // NOTE: all state here uses non-blocking assignments so each register samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         lat_cnt   <= '0;
         prio_wr   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 1'b0;
         DIN       <= 1'b0;
         DGWCLK    <= '0;
         RWL       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_ready) begin
                  state  <= WR_SETUP;
                  DIN    <= wr_data;
                  addr_q <= wr_addr;
                  // A contested grant hands priority to the loser.
                  if (rd_valid) prio_wr <= ~prio_wr;
               end else if (rd_ready) begin
                  state   <= RD_SEL;
                  RWL     <= onehot(rd_addr);
                  lat_cnt <= 3'(RD_LAT);
                  if (wr_valid) prio_wr <= ~prio_wr;
               end
            end
            WR_SETUP: begin
               // The slice has registered DIN into GDIN on this edge; open the latch.
               DGWCLK <= onehot(addr_q);
               state  <= WR_PULSE;
            end
            WR_PULSE: begin
               DGWCLK <= '0;
               state  <= WR_HOLD;
            end
            WR_HOLD: begin
               // Extra cycle keeps DIN/GDIN stable past the latch closing edge.
               state <= IDLE;
            end
            RD_SEL: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  rsp_data  <= DOUT;
                  rsp_valid <= 1'b1;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  RWL       <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
